// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the write-back data cache.
// Field widths derive from LINES / WORDS_PER_LINE so callers never hand-slice addresses.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL,
        FLUSH
    } state_t;

    function automatic int index_width(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int woff_width(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int tag_width(input int lines, input int words_per_line);
        return 32 - $clog2(lines) - $clog2(words_per_line) - 2;
    endfunction

    function automatic logic [31:0] addr_word(input logic [31:0] addr, input int woff_w);
        return (addr >> 2) & ((32'd1 << woff_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int woff_w,
                                               input int index_w);
        return (addr >> (2 + woff_w)) & ((32'd1 << index_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int woff_w,
                                             input int index_w);
        return addr >> (2 + woff_w + index_w);
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Line storage for the data cache: valid/dirty bits (reset), tags and data words (not reset).
// One combinational read port and one byte-enabled write port share the same line index.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int LINES          = 4,
    parameter int WORDS_PER_LINE = 4,
    localparam int INDEX_W       = index_width(LINES),
    localparam int WOFF_W        = woff_width(WORDS_PER_LINE),
    localparam int TAG_W         = tag_width(LINES, WORDS_PER_LINE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] idx,
    input  logic [WOFF_W-1:0]  rd_word,
    output logic [31:0]        rd_data,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    input  logic               wr_en,
    input  logic [WOFF_W-1:0]  wr_word,
    input  logic [31:0]        wr_data,
    input  logic [3:0]         wr_be,
    input  logic               meta_en,
    input  logic [TAG_W-1:0]   meta_tag,
    input  logic               meta_dirty
);

    logic [31:0]      data_mem [LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;

    assign rd_data  = data_mem[idx][rd_word];
    assign rd_valid = valid[idx];
    assign rd_dirty = dirty[idx];
    assign rd_tag   = tag_mem[idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    data_mem[idx][wr_word][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
        if (meta_en) begin
            tag_mem[idx] <= meta_tag;
        end
    end

    // A metadata update always leaves the line valid; only reset invalidates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (meta_en) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= meta_dirty;
        end
    end

endmodule

// File: rtl/data_cache_wb.sv
// Direct-mapped write-back, write-allocate data cache with explicit flush.
// Backing memory is driven one word per mem_ready handshake from the FSM state.
module data_cache_wb
    import dcache_pkg::*;
#(
    parameter int LINES          = 4,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_read_en,
    input  logic        cpu_write_en,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byte_en,
    input  logic        flush,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        flush_done,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int INDEX_W = index_width(LINES);
    localparam int WOFF_W  = woff_width(WORDS_PER_LINE);
    localparam int TAG_W   = tag_width(LINES, WORDS_PER_LINE);

    state_t             state;
    logic [WOFF_W-1:0]  word_cnt;
    logic [INDEX_W-1:0] line_ptr;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [WOFF_W-1:0]  req_word;
    logic [INDEX_W-1:0] idx;
    logic [WOFF_W-1:0]  rd_word;
    logic [31:0]        rd_data;
    logic               rd_valid;
    logic               rd_dirty;
    logic [TAG_W-1:0]   rd_tag;
    logic               wr_en;
    logic [WOFF_W-1:0]  wr_word;
    logic [31:0]        wr_data;
    logic [3:0]         wr_be;
    logic               meta_en;
    logic [TAG_W-1:0]   meta_tag;
    logic               meta_dirty;
    logic               hit;
    logic               cpu_req;
    logic               victim_dirty;
    logic               word_last;
    logic               line_last;

    assign req_tag  = TAG_W'(addr_tag(cpu_addr, WOFF_W, INDEX_W));
    assign req_idx  = INDEX_W'(addr_index(cpu_addr, WOFF_W, INDEX_W));
    assign req_word = WOFF_W'(addr_word(cpu_addr, WOFF_W));

    // During FLUSH the arrays are walked by line_ptr; otherwise the live request selects the line.
    assign idx     = (state == FLUSH) ? line_ptr : req_idx;
    assign rd_word = (state == IDLE) ? req_word : word_cnt;

    assign hit          = rd_valid && (rd_tag == req_tag);
    assign cpu_req      = cpu_read_en || cpu_write_en;
    assign victim_dirty = rd_valid && rd_dirty;
    assign word_last    = (word_cnt == WOFF_W'(WORDS_PER_LINE - 1));
    assign line_last    = (line_ptr == INDEX_W'(LINES - 1));

    assign cpu_stall = (state != IDLE) || flush || (cpu_req && !hit);
    assign cpu_rdata = (state == IDLE && cpu_read_en && hit && !flush) ? rd_data : 32'h0;

    dcache_line_store #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_store (
        .clk        (clk),
        .reset      (reset),
        .idx        (idx),
        .rd_word    (rd_word),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .wr_en      (wr_en),
        .wr_word    (wr_word),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .meta_en    (meta_en),
        .meta_tag   (meta_tag),
        .meta_dirty (meta_dirty)
    );

    always_comb begin
        wr_en        = 1'b0;
        wr_word      = req_word;
        wr_data      = cpu_wdata;
        wr_be        = cpu_byte_en;
        meta_en      = 1'b0;
        meta_tag     = rd_tag;
        meta_dirty   = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        case (state)
            IDLE: begin
                if (cpu_write_en && hit && !flush) begin
                    wr_en      = 1'b1;
                    meta_en    = 1'b1;
                    meta_dirty = 1'b1;
                end
            end
            WRITEBACK: begin
                mem_write_en = 1'b1;
                mem_addr     = {rd_tag, req_idx, word_cnt, 2'b00};
                mem_wdata    = rd_data;
                meta_en      = mem_ready && word_last;
            end
            REFILL: begin
                mem_read_en = 1'b1;
                mem_addr    = {req_tag, req_idx, word_cnt, 2'b00};
                if (mem_ready) begin
                    wr_en    = 1'b1;
                    wr_word  = word_cnt;
                    wr_data  = mem_rdata;
                    wr_be    = 4'hF;
                    meta_en  = word_last;
                    meta_tag = req_tag;
                end
            end
            FLUSH: begin
                if (victim_dirty) begin
                    mem_write_en = 1'b1;
                    mem_addr     = {rd_tag, line_ptr, word_cnt, 2'b00};
                    mem_wdata    = rd_data;
                    meta_en      = mem_ready && word_last;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            word_cnt   <= '0;
            line_ptr   <= '0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        state    <= FLUSH;
                        line_ptr <= '0;
                        word_cnt <= '0;
                    end else if (cpu_req && !hit) begin
                        word_cnt <= '0;
                        state    <= victim_dirty ? WRITEBACK : REFILL;
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (word_last) state <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (word_last) state <= IDLE;
                    end
                end
                FLUSH: begin
                    // Clean or invalid lines cost one cycle; dirty lines advance after their last word.
                    if (!victim_dirty || (mem_ready && word_last)) begin
                        word_cnt <= '0;
                        if (line_last) begin
                            state      <= IDLE;
                            flush_done <= 1'b1;
                        end else begin
                            line_ptr <= line_ptr + 1'b1;
                        end
                    end else if (mem_ready) begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache_wb.sv
// Bench for data_cache_wb: directed scenarios plus random loads/stores/flushes,
// checked against a CPU-visible memory view and a line-level hit/dirty model.
module tb_data_cache_wb;

  localparam int LINES      = 4;
  localparam int WPL        = 4;
  localparam int LINE_BYTES = 4 * WPL;
  localparam int BUDGET     = 500;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read_en, cpu_write_en, flush;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_byte_en;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, flush_done;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;

  data_cache_wb #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_read_en  (cpu_read_en),
    .cpu_write_en (cpu_write_en),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_byte_en  (cpu_byte_en),
    .flush        (flush),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .flush_done   (flush_done),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check / report ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mem_m  [logic [31:0]];   // backing memory as written by the DUT
  logic [31:0] shadow [logic [31:0]];   // what the CPU should observe
  logic [31:0] exp_q[$], exp_wq[$], exp_rq[$];
  logic [31:0] wr_log[$], wd_log[$], rd_log[$];
  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  int          m_tag   [LINES];
  int          lat = 1;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {16'hA5A5, a[15:0]};
  endfunction

  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    return mem_rd(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    shadow.delete();
  endtask

  task automatic push_line_writes(input int line);
    logic [31:0] base;
    base = 32'((m_tag[line] * LINES + line) * LINE_BYTES);
    for (int w = 0; w < WPL; w++) begin
      exp_q.push_back(base + 32'(4 * w));
      exp_wq.push_back(shadow_rd(base + 32'(4 * w)));
    end
  endtask

  task automatic model_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be, output int exp_stall,
                              output logic [31:0] exp_rd);
    int line, tag;
    logic [31:0] word;
    line = int'(a / LINE_BYTES) % LINES;
    tag  = int'(a / (LINE_BYTES * LINES));
    if (m_valid[line] && m_tag[line] == tag) begin
      exp_stall = 0;
    end else begin
      if (m_valid[line] && m_dirty[line]) begin
        push_line_writes(line);
        exp_stall = 1 + 2 * WPL * lat;
      end else begin
        exp_stall = 1 + WPL * lat;
      end
      for (int w = 0; w < WPL; w++) exp_rq.push_back(a - (a % LINE_BYTES) + 32'(4 * w));
      m_valid[line] = 1;
      m_tag[line]   = tag;
      m_dirty[line] = 0;
    end
    exp_rd = wr ? 32'h0 : shadow_rd(a);
    if (wr) begin
      word = shadow_rd(a);
      for (int b = 0; b < 4; b++) if (be[b]) word[b*8 +: 8] = d[b*8 +: 8];
      shadow[a] = word;
      m_dirty[line] = 1;
    end
  endtask

  // ---------------- memory responder (ready on the lat-th cycle of each word) ----------------
  int          req_cycles = 0;
  logic        pend_write;
  logic [31:0] pend_addr, pend_data;

  always @(negedge clk) begin
    if (mem_ready) begin
      if (pend_write) begin
        mem_m[pend_addr] = pend_data;
        wr_log.push_back(pend_addr);
        wd_log.push_back(pend_data);
      end else begin
        rd_log.push_back(pend_addr);
      end
      req_cycles = 0;
    end
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    if (!reset) check("mem_excl", {31'b0, mem_read_en & mem_write_en}, 32'h0);
    if (!reset && (mem_read_en || mem_write_en)) begin
      req_cycles++;
      if (req_cycles >= lat) begin
        mem_ready  = 1'b1;
        pend_write = mem_write_en;
        pend_addr  = mem_addr;
        pend_data  = mem_wdata;
        mem_rdata  = mem_read_en ? mem_rd(mem_addr) : 32'h0;
      end
    end else begin
      req_cycles = 0;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic compare_traffic(input string tag);
    check({tag, "_nwr"}, 32'(wr_log.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && wr_log.size() > 0) begin
      check({tag, "_wr_addr"}, wr_log.pop_front(), exp_q.pop_front());
      check({tag, "_wr_data"}, wd_log.pop_front(), exp_wq.pop_front());
    end
    check({tag, "_nrd"}, 32'(rd_log.size()), 32'(exp_rq.size()));
    while (exp_rq.size() > 0 && rd_log.size() > 0) begin
      check({tag, "_rd_addr"}, rd_log.pop_front(), exp_rq.pop_front());
    end
    exp_q.delete(); exp_wq.delete(); exp_rq.delete();
    wr_log.delete(); wd_log.delete(); rd_log.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rdata"}, cpu_rdata, 32'h0);
    check({tag, "_stall"}, {31'b0, cpu_stall}, 32'h0);
    check({tag, "_flush_done"}, {31'b0, flush_done}, 32'h0);
    check({tag, "_mem_rd"}, {31'b0, mem_read_en}, 32'h0);
    check({tag, "_mem_wr"}, {31'b0, mem_write_en}, 32'h0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  // ---------------- drivers (entered and left at posedge + #1) ----------------
  task automatic do_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input string tag);
    int exp_stall, n;
    logic [31:0] exp_rd, got;
    bit done;
    model_access(wr, a, d, be, exp_stall, exp_rd);
    cpu_read_en  = !wr;
    cpu_write_en = wr;
    cpu_addr     = a;
    cpu_wdata    = d;
    cpu_byte_en  = be;
    done = 0;
    got  = 32'h0;
    for (n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if (!cpu_stall) begin
        got  = cpu_rdata;
        done = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, "_accepted"}, {31'b0, done}, 32'h1);
    check({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    check({tag, "_rdata"}, got, exp_rd);
    @(posedge clk); #1;
    cpu_read_en  = 1'b0;
    cpu_write_en = 1'b0;
    compare_traffic(tag);
  endtask

  task automatic do_flush(input string tag);
    int exp_cyc, n;
    bit seen;
    exp_cyc = 1;
    for (int i = 0; i < LINES; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        push_line_writes(i);
        m_dirty[i] = 0;
        exp_cyc += WPL * lat;
      end else begin
        exp_cyc += 1;
      end
    end
    flush = 1'b1;
    @(negedge clk);
    check({tag, "_stall"}, {31'b0, cpu_stall}, 32'h1);
    @(posedge clk); #1;
    flush = 1'b0;
    seen = 0;
    for (n = 1; n < BUDGET; n++) begin
      @(negedge clk);
      if (flush_done) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, "_done_seen"}, {31'b0, seen}, 32'h1);
    check({tag, "_done_cycle"}, 32'(n), 32'(exp_cyc));
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'b0, flush_done}, 32'h0);
    @(posedge clk); #1;
    compare_traffic(tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    logic [31:0] a;
    int op;
    reset = 1'b1;
    cpu_read_en = 1'b0; cpu_write_en = 1'b0; flush = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_byte_en = 4'h0;
    mem_m[32'h100] = 32'hA5A5_0001;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;

    lat = 2;
    do_access(1'b0, 32'h100, 32'h0, 4'h0, "load_100_miss");
    do_access(1'b0, 32'h104, 32'h0, 4'h0, "load_104_hit");
    do_access(1'b1, 32'h104, 32'hDEADBEEF, 4'b0011, "store_104_hit");
    do_access(1'b0, 32'h104, 32'h0, 4'h0, "load_104_merged");

    lat = 1;
    do_access(1'b0, 32'h140, 32'h0, 4'h0, "load_140_dirty_miss");
    do_access(1'b1, 32'h200, 32'h12345678, 4'hF, "store_200_miss");
    do_access(1'b0, 32'h200, 32'h0, 4'h0, "load_200");
    check("mem_200_unchanged", mem_rd(32'h200), 32'hA5A5_0200);
    do_access(1'b1, 32'h214, 32'hCAFE_F00D, 4'b1100, "store_214_miss");

    lat = 2;
    do_flush("flush_two_dirty");
    do_flush("flush_clean");

    // Reset in the middle of refilling word 2 of line 0x300.
    cpu_read_en = 1'b1;
    cpu_addr    = 32'h300;
    found = 0;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if (mem_read_en && mem_addr == 32'h308) begin
        found = 1;
        break;
      end
    end
    check("rst_reach_word2", {31'b0, found}, 32'h1);
    #1;
    reset = 1'b1;
    cpu_read_en = 1'b0;
    cpu_addr    = 32'h0;
    @(negedge clk);
    check_outputs_zero("mid_refill_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    exp_q.delete(); exp_wq.delete(); exp_rq.delete();
    wr_log.delete(); wd_log.delete(); rd_log.delete();
    do_access(1'b0, 32'h300, 32'h0, 4'h0, "reload_300_miss");

    // Random traffic over a window that maps four tags onto every line.
    for (int k = 0; k < 60; k++) begin
      lat = $urandom_range(1, 3);
      op  = $urandom_range(0, 9);
      a   = 32'h1000 + 32'(4 * $urandom_range(0, 63));
      if (op < 5)
        do_access(1'b0, a, 32'h0, 4'h0, "rnd_load");
      else if (op < 9)
        do_access(1'b1, a, $urandom, 4'($urandom_range(0, 15)), "rnd_store");
      else
        do_flush("rnd_flush");
    end
    lat = 1;
    do_flush("final_flush");
    for (int i = 0; i < 64; i++) begin
      a = 32'h1000 + 32'(4 * i);
      check("final_mem", mem_rd(a), shadow_rd(a));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
